mul_div_unit: RTL
=================

// Module: mul_div_unit
// PURPOSE
//  Parametrised multi-cycle multiply/divide unit with HI/LO registers for the 5-stage MIPS core.
//  Sits in the Execute stage beside the ALU and is driven by E-stage decode.
//  Asserts busy for a programmable latency; the hazard unit stalls D whenever an MD-class instruction
//  (mult/div/mfhi/mflo/mthi/mtlo) is in D while (start || busy).
//  Successor of the fixed 32-bit mult/div: width, per-op latency and accumulate modes are configurable.
// PARAMETERS
//  WIDTH        32  operand / HI / LO width in bits (>=8)
//  MULT_CYCLES  5   busy cycles after an accepted mult/multu (>=1)
//  DIV_CYCLES   10  busy cycles after an accepted div/divu (>=1)
// PORTS
//  clk    in   1       clock, rising edge
//  reset  in   1       asynchronous, active-high; clears all state
//  start  in   1       E-stage MD instruction valid (already qualified by !E_lat)
//  op     in   3       operation, encoding from mdu_pkg
//  a      in   WIDTH   rs operand (forwarded value)
//  b      in   WIDTH   rt operand (forwarded value)
//  busy   out  1       long operation in progress
//  hi     out  WIDTH   architectural HI register
//  lo     out  WIDTH   architectural LO register
// BEHAVIOUR
//  - Reset (async): busy=0, hi=0, lo=0, cnt=0, pending=0, regardless of clock.
//  - States: IDLE (busy=0) / RUN (busy=1, cnt!=0).
//  - IDLE + start + op in {MULT,MULTU}: compute the full 2*WIDTH product into pend_hi/pend_lo;
//    cnt<=MULT_CYCLES; busy<=1.
//  - IDLE + start + op in {DIV,DIVU}: pend_lo<=quotient, pend_hi<=remainder; cnt<=DIV_CYCLES; busy<=1.
//  - IDLE + start + MTHI/MTLO: hi<=a (resp. lo<=a) on the same edge; busy stays 0; latency 1.
//  - RUN, each edge: cnt<=cnt-1. When cnt==1, hi<=pend_hi, lo<=pend_lo, busy<=0 on that edge.
//    busy is therefore high for exactly N cycles after the accept edge; HI/LO are valid on the cycle busy falls.
//  - start while busy: ignored (the hazard stall guarantees this never occurs; assertion in the bench).
//  - HI/LO are unchanged during RUN; a stalled mfhi/mflo reads them only after busy falls.
//  - Signed ops are two's complement. Remainder takes the sign of the dividend; quotient truncates toward zero.
//  - Divide by zero: lo<=all ones, hi<=a (both signed and unsigned). Latency is unchanged.
//  - Signed overflow (a=MIN, b=-1): lo<=MIN, hi<=0.
//  - Reset mid-RUN: the pending result is discarded; HI/LO return to 0.
//  - Unused op codes: no effect.
// CONFIGURATION
//  MDU_MADD_EN defined: ops MADD, MADDU, MSUB, MSUBU are accepted.
//    {hi,lo} +/- the product of a and b is computed at the accept edge from the current {hi,lo}.
//    The result commits after MULT_CYCLES. Wrap-around is modulo 2^(2*WIDTH).
//  MDU_MADD_EN undefined: these encodings are treated as unused (no effect, busy stays 0).
// STRUCTURE
//  - mdu_pkg:
//      op encodings MDU_MULT=0, MDU_MULTU=1, MDU_DIV=2, MDU_DIVU=3, MDU_MTHI=4, MDU_MTLO=5,
//      MDU_MADD=6, MDU_MSUB=7 (unsigned variants select by a single sign-mode bit when enabled);
//      width of cnt = clog2(max(MULT_CYCLES,DIV_CYCLES)+1).
//  - Sub-module mdu_arith: combinational product/quotient/remainder with the corner-case rules above.
//    The top holds cnt, busy, pend_hi/pend_lo, hi, lo.
// TESTING
//  1. mult a=-3, b=7, MULT_CYCLES=5:
//     busy=1 for 5 cycles; then hi=32'hFFFFFFFF, lo=32'hFFFFFFEB.
//  2. divu a=100, b=7, DIV_CYCLES=10:
//     busy 10 cycles; lo=14, hi=2. div a=-7, b=2: lo=-3, hi=-1.
//  3. div a=5, b=0 -> lo=32'hFFFFFFFF, hi=5.
//     div a=32'h80000000, b=-1 -> lo=32'h80000000, hi=0.
//  4. mthi a=32'h1234 while idle -> hi=32'h1234 next cycle, busy stays 0.
//     Then start div and assert reset at cnt=4 -> busy=0, hi=lo=0 immediately (async).
//  5. Back-to-back mult then mflo in the full core:
//     D stalls until busy falls; mflo returns the product; no stall when no MD op is in flight.
//  6. MDU_MADD_EN: hi=0, lo=32'hFFFFFFFF, maddu a=1, b=1 -> hi=1, lo=0 after 5 cycles.
//     Without the macro, the same op leaves hi/lo unchanged.

Source files
------------

// File: rtl/mdu_pkg.sv
// Shared definitions for the multiply/divide unit: op encodings and counter sizing.
// Optional multiply-accumulate ops are enabled by defining MDU_MADD_EN.
package mdu_pkg;

    typedef enum logic [2:0] {
        MDU_MULT  = 3'd0,
        MDU_MULTU = 3'd1,
        MDU_DIV   = 3'd2,
        MDU_DIVU  = 3'd3,
        MDU_MTHI  = 3'd4,
        MDU_MTLO  = 3'd5,
        MDU_MADD  = 3'd6,
        MDU_MSUB  = 3'd7
    } mdu_op_e;

    // Sign mode for madd/msub: 1 = signed (madd/msub), 0 = unsigned (maddu/msubu).
    localparam logic MDU_ACC_SIGNED = 1'b0;

    function automatic int cnt_width(input int m, input int d);
        return $clog2(((m > d) ? m : d) + 1);
    endfunction

endpackage

// File: rtl/mdu_arith.sv
// Combinational product, quotient/remainder and accumulate datapath.
// Handles divide-by-zero and signed-overflow cases for the MDU.
module mdu_arith
    import mdu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] acc_hi,
    input  logic [WIDTH-1:0] acc_lo,
    output logic [WIDTH-1:0] res_hi,
    output logic [WIDTH-1:0] res_lo
);

    logic               is_div;
    logic               is_acc;
    logic               sgn;
    logic [2*WIDTH-1:0] ea;
    logic [2*WIDTH-1:0] eb;
    logic [2*WIDTH-1:0] prod;
    logic [2*WIDTH-1:0] mac;
    logic               neg_a;
    logic               neg_b;
    logic [WIDTH-1:0]   mag_a;
    logic [WIDTH-1:0]   mag_b;
    logic [WIDTH-1:0]   dvs;
    logic [WIDTH-1:0]   uq;
    logic [WIDTH-1:0]   ur;
    logic [WIDTH-1:0]   q;
    logic [WIDTH-1:0]   r;

    assign is_div = (op == MDU_DIV) || (op == MDU_DIVU);
    assign is_acc = (op == MDU_MADD) || (op == MDU_MSUB);
    assign sgn    = is_acc ? MDU_ACC_SIGNED : ~op[0];

    assign ea   = sgn ? {{WIDTH{a[WIDTH-1]}}, a} : {{WIDTH{1'b0}}, a};
    assign eb   = sgn ? {{WIDTH{b[WIDTH-1]}}, b} : {{WIDTH{1'b0}}, b};
    assign prod = ea * eb;
    assign mac  = (op == MDU_MSUB) ? {acc_hi, acc_lo} - prod
                                   : {acc_hi, acc_lo} + prod;

    // Magnitude division: MIN / -1 falls out as MIN rem 0 without a special case.
    assign neg_a = sgn & a[WIDTH-1];
    assign neg_b = sgn & b[WIDTH-1];
    assign mag_a = neg_a ? -a : a;
    assign mag_b = neg_b ? -b : b;
    assign dvs   = (b == '0) ? WIDTH'(1) : mag_b;
    assign uq    = mag_a / dvs;
    assign ur    = mag_a % dvs;
    assign q     = (neg_a ^ neg_b) ? -uq : uq;
    assign r     = neg_a ? -ur : ur;

    always_comb begin
        {res_hi, res_lo} = prod;
        if (is_div) begin
            res_hi = (b == '0) ? a  : r;
            res_lo = (b == '0) ? '1 : q;
        end else if (is_acc) begin
            {res_hi, res_lo} = mac;
        end
    end

endmodule

// File: rtl/mul_div_unit.sv
// Multi-cycle multiply/divide unit with HI/LO for the E stage.
// Define MDU_MADD_EN to accept madd/msub accumulate ops.
module mul_div_unit
    import mdu_pkg::*;
#(
    parameter int WIDTH       = 32,
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = cnt_width(MULT_CYCLES, DIV_CYCLES);

    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] pend_hi;
    logic [WIDTH-1:0] pend_lo;
    logic [WIDTH-1:0] res_hi;
    logic [WIDTH-1:0] res_lo;
    logic             is_mul;
    logic             is_div;
    logic             is_mac;
    logic             is_mthi;
    logic             is_mtlo;

    assign is_mul  = (op == MDU_MULT) || (op == MDU_MULTU);
    assign is_div  = (op == MDU_DIV)  || (op == MDU_DIVU);
    assign is_mthi = (op == MDU_MTHI);
    assign is_mtlo = (op == MDU_MTLO);
`ifdef MDU_MADD_EN
    assign is_mac  = (op == MDU_MADD) || (op == MDU_MSUB);
`else
    assign is_mac  = 1'b0;
`endif

    mdu_arith #(
        .WIDTH (WIDTH)
    ) u_arith (
        .op     (op),
        .a      (a),
        .b      (b),
        .acc_hi (hi),
        .acc_lo (lo),
        .res_hi (res_hi),
        .res_lo (res_lo)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            busy    <= 1'b0;
            cnt     <= '0;
            pend_hi <= '0;
            pend_lo <= '0;
            hi      <= '0;
            lo      <= '0;
        end else if (busy) begin
            cnt <= cnt - CW'(1);
            if (cnt == CW'(1)) begin
                hi   <= pend_hi;
                lo   <= pend_lo;
                busy <= 1'b0;
            end
        end else if (start) begin
            unique case (1'b1)
                is_mul, is_mac: begin
                    pend_hi <= res_hi;
                    pend_lo <= res_lo;
                    cnt     <= CW'(MULT_CYCLES);
                    busy    <= 1'b1;
                end
                is_div: begin
                    pend_hi <= res_hi;
                    pend_lo <= res_lo;
                    cnt     <= CW'(DIV_CYCLES);
                    busy    <= 1'b1;
                end
                is_mthi: hi <= a;
                is_mtlo: lo <= a;
                default: ;
            endcase
        end
    end

endmodule
